// File: rtl/dbus_router_pkg.sv
// Shared types and constants for the data-bus router: request/response
// records, route tags carried by the per-port FIFOs, and the kseg mapping.
`default_nettype none

package dbus_router_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

  typedef struct packed {
    logic       uncached;
    logic [1:0] lane;
  } route_tag_t;

  localparam logic [2:0]  UNCACHED_SEG_DEFAULT = 3'b101;
  localparam logic [31:0] KSEG_MASK            = 32'h1FFF_FFFF;

  // kseg0/kseg1 fold onto the low 512 MiB; every other segment is identity-mapped.
  function automatic logic [31:0] to_paddr(input logic [31:0] vaddr);
    return (vaddr[31:30] == 2'b10) ? (vaddr & KSEG_MASK) : vaddr;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dbus_route_fifo.sv
// Per-port FIFO of route tags recording which backend owns each outstanding request.
`default_nettype none

module dbus_route_fifo
  import dbus_router_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  route_tag_t push_tag,
  output route_tag_t head,
  output logic       full,
  output logic       empty
);

  localparam int              PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              CW    = $clog2(DEPTH) + 1;
  localparam int              SLOTS = 2 ** PW;
  localparam logic [PW-1:0]   LAST  = PW'(DEPTH - 1);
  localparam logic [CW-1:0]   CAP   = CW'(DEPTH);

  route_tag_t    mem [SLOTS];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CAP);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_tag;
        wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/dbus_router.sv
// Data-side front end: kseg translation, cached/uncached steering, DCache lane packing
// and in-order response routing. Optional DBUS_ROUTER_PERF_EN adds per-port accept counters.
`default_nettype none

module dbus_router
  import dbus_router_pkg::*;
#(
  parameter int         NUM_PORTS       = 2,
  parameter int         MAX_OUTSTANDING = 2,
  parameter logic [2:0] UNCACHED_SEG    = UNCACHED_SEG_DEFAULT
) (
  input  logic                        clk,
  input  logic                        reset,
  input  dbus_req_t  [NUM_PORTS-1:0]  dreq,
  output dbus_resp_t [NUM_PORTS-1:0]  dresp,
  output dbus_req_t  [NUM_PORTS-1:0]  cache_req,
  input  dbus_resp_t [NUM_PORTS-1:0]  cache_resp,
  output dbus_req_t  [NUM_PORTS-1:0]  uc_req,
  input  dbus_resp_t [NUM_PORTS-1:0]  uc_resp
`ifdef DBUS_ROUTER_PERF_EN
  ,
  output logic [NUM_PORTS-1:0][1:0][31:0] perf_cnt
`endif
);

  logic [NUM_PORTS-1:0] uncached;
  logic [NUM_PORTS-1:0] issue;
  logic [NUM_PORTS-1:0] accept;
  logic [NUM_PORTS-1:0] full;
  logic [NUM_PORTS-1:0] empty;
  logic [NUM_PORTS-1:0] lane_claimed;
  logic [1:0]           lane     [NUM_PORTS];
  route_tag_t           push_tag [NUM_PORTS];
  route_tag_t           head     [NUM_PORTS];

  // Lanes are handed out densely, in port order, only to requests actually issued.
  always_comb begin
    logic [1:0] used;
    used = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      uncached[i] = (dreq[i].addr[31:29] == UNCACHED_SEG);
      issue[i]    = dreq[i].valid & ~full[i];
      lane[i]     = used;
      push_tag[i] = '{uncached: uncached[i], lane: used};
      if (issue[i] && !uncached[i]) used = used + 2'd1;
    end
  end

  always_comb begin
    dbus_req_t phys;
    phys      = '0;
    cache_req = '0;
    uc_req    = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      phys       = dreq[i];
      phys.valid = issue[i];
      phys.addr  = to_paddr(dreq[i].addr);
      if (issue[i] && uncached[i]) uc_req[i] = phys;
      for (int l = 0; l < NUM_PORTS; l++) begin
        if (issue[i] && !uncached[i] && lane[i] == 2'(l)) cache_req[l] = phys;
      end
    end
  end

  always_comb begin
    dbus_resp_t issue_src;
    dbus_resp_t ret_src;
    logic       aok;
    issue_src    = '0;
    ret_src      = '0;
    aok          = 1'b0;
    dresp        = '0;
    accept       = '0;
    lane_claimed = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      issue_src = uc_resp[i];
      ret_src   = uc_resp[i];
      for (int l = 0; l < NUM_PORTS; l++) begin
        if (!uncached[i] && lane[i] == 2'(l)) issue_src = cache_resp[l];
        if (!head[i].uncached && head[i].lane == 2'(l)) begin
          ret_src = cache_resp[l];
          if (!empty[i]) lane_claimed[l] = 1'b1;
        end
      end
      aok              = issue_src.addr_ok & ~full[i];
      dresp[i].addr_ok = aok;
      dresp[i].data_ok = ~empty[i] & ret_src.data_ok;
      dresp[i].data    = empty[i] ? '0 : ret_src.data;
      accept[i]        = issue[i] & aok;
    end
  end

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_fifo
    dbus_route_fifo #(
      .DEPTH(MAX_OUTSTANDING)
    ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (accept[i]),
      .pop     (dresp[i].data_ok),
      .push_tag(push_tag[i]),
      .head    (head[i]),
      .full    (full[i]),
      .empty   (empty[i])
    );
  end

  // A backend completing with nothing waiting for it means an ordering bug upstream.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int l = 0; l < NUM_PORTS; l++) begin
        assert (!cache_resp[l].data_ok || lane_claimed[l])
          else $warning("dbus_router: orphan data_ok on cache lane %0d", l);
        assert (!uc_resp[l].data_ok || (!empty[l] && head[l].uncached))
          else $warning("dbus_router: orphan data_ok on uncached port %0d", l);
      end
    end
  end

`ifdef DBUS_ROUTER_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (accept[i]) begin
          if (uncached[i]) perf_cnt[i][0] <= perf_cnt[i][0] + 32'd1;
          else             perf_cnt[i][1] <= perf_cnt[i][1] + 32'd1;
        end
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_dbus_router.sv
// Directed bench for dbus_router: a vector table for the combinational steering path,
// then hand-written multi-cycle sequences for ordering, backpressure and reset.
`default_nettype none

module tb_dbus_router;
  import dbus_router_pkg::*;

  localparam int NP = 2;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  dbus_req_t  [NP-1:0]  dreq;
  dbus_resp_t [NP-1:0]  dresp;
  dbus_req_t  [NP-1:0]  cache_req;
  dbus_resp_t [NP-1:0]  cache_resp;
  dbus_req_t  [NP-1:0]  uc_req;
  dbus_resp_t [NP-1:0]  uc_resp;
`ifdef DBUS_ROUTER_PERF_EN
  logic [NP-1:0][1:0][31:0] perf_cnt;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dbus_router #(
    .NUM_PORTS      (NP),
    .MAX_OUTSTANDING(2),
    .UNCACHED_SEG   (3'b101)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .dreq      (dreq),
    .dresp     (dresp),
    .cache_req (cache_req),
    .cache_resp(cache_resp),
    .uc_req    (uc_req),
    .uc_resp   (uc_resp)
`ifdef DBUS_ROUTER_PERF_EN
    ,
    .perf_cnt  (perf_cnt)
`endif
  );

  typedef struct {
    logic [1:0]  v;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [1:0]  caok;
    logic [1:0]  uaok;
    int          cs0;
    logic [31:0] ca0;
    int          cs1;
    logic [31:0] ca1;
    logic [1:0]  uv;
    logic [31:0] ua0;
    logic [31:0] ua1;
    logic [1:0]  aok;
  } vec_t;

  vec_t vecs [8];

  // Each port carries distinct side fields so a misrouted request is visible.
  function automatic dbus_req_t mkreq(input int src, input logic [31:0] a, input logic v);
    dbus_req_t r;
    r        = '0;
    r.valid  = v;
    r.addr   = a;
    r.size   = (src == 0) ? 3'd2 : 3'd1;
    r.strobe = (src == 0) ? 4'hF : 4'h3;
    r.data   = (src == 0) ? 32'h1111_1111 : 32'h2222_2222;
    return r;
  endfunction

  function automatic dbus_req_t exp_lane(input int src, input logic [31:0] pa);
    return (src < 0) ? dbus_req_t'('0) : mkreq(src, pa, 1'b1);
  endfunction

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    dreq       = '0;
    cache_resp = '0;
    uc_resp    = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    vecs[0] = '{2'b01, 32'h8000_0010, 32'h0000_0000, 2'b11, 2'b11, 0, 32'h0000_0010, -1, 32'h0, 2'b00, 32'h0, 32'h0, 2'b11};
    vecs[1] = '{2'b11, 32'hBFC0_0000, 32'h8000_0100, 2'b11, 2'b11, 1, 32'h0000_0100, -1, 32'h0, 2'b01, 32'h1FC0_0000, 32'h0, 2'b11};
    vecs[2] = '{2'b11, 32'h0000_1234, 32'hA000_0004, 2'b11, 2'b11, 0, 32'h0000_1234, -1, 32'h0, 2'b10, 32'h0, 32'h0000_0004, 2'b11};
    vecs[3] = '{2'b11, 32'h9FFF_FFFC, 32'hC000_0008, 2'b11, 2'b11, 0, 32'h1FFF_FFFC, 1, 32'hC000_0008, 2'b00, 32'h0, 32'h0, 2'b11};
    vecs[4] = '{2'b11, 32'hA000_0000, 32'hBFFF_FFF0, 2'b11, 2'b01, -1, 32'h0, -1, 32'h0, 2'b11, 32'h0000_0000, 32'h1FFF_FFF0, 2'b01};
    vecs[5] = '{2'b11, 32'h8000_0000, 32'h0000_0040, 2'b10, 2'b11, 0, 32'h0000_0000, 1, 32'h0000_0040, 2'b00, 32'h0, 32'h0, 2'b10};
    vecs[6] = '{2'b01, 32'hE000_0000, 32'hA000_0000, 2'b11, 2'b01, 0, 32'hE000_0000, -1, 32'h0, 2'b00, 32'h0, 32'h0, 2'b01};
    vecs[7] = '{2'b10, 32'h8000_0000, 32'h8000_0200, 2'b01, 2'b11, 1, 32'h0000_0200, -1, 32'h0, 2'b00, 32'h0, 32'h0, 2'b11};

    clear_inputs();
    @(negedge clk);
    #1;
    chk("reset dresp",     80'(dresp),     80'(0));
    chk("reset cache_req", 80'(cache_req), 80'(0));
    chk("reset uc_req",    80'(uc_req),    80'(0));
    @(negedge clk);
    reset = 1'b0;

    for (int k = 0; k < 8; k++) begin
      dreq[0]               = mkreq(0, vecs[k].a0, vecs[k].v[0]);
      dreq[1]               = mkreq(1, vecs[k].a1, vecs[k].v[1]);
      cache_resp[0].addr_ok = vecs[k].caok[0];
      cache_resp[1].addr_ok = vecs[k].caok[1];
      uc_resp[0].addr_ok    = vecs[k].uaok[0];
      uc_resp[1].addr_ok    = vecs[k].uaok[1];
      #1;
      chk($sformatf("vec%0d cache_req0", k), 80'(cache_req[0]), 80'(exp_lane(vecs[k].cs0, vecs[k].ca0)));
      chk($sformatf("vec%0d cache_req1", k), 80'(cache_req[1]), 80'(exp_lane(vecs[k].cs1, vecs[k].ca1)));
      chk($sformatf("vec%0d uc_req0", k), 80'(uc_req[0]), 80'(exp_lane(vecs[k].uv[0] ? 0 : -1, vecs[k].ua0)));
      chk($sformatf("vec%0d uc_req1", k), 80'(uc_req[1]), 80'(exp_lane(vecs[k].uv[1] ? 1 : -1, vecs[k].ua1)));
      chk($sformatf("vec%0d addr_ok", k), 80'({dresp[1].addr_ok, dresp[0].addr_ok}), 80'(vecs[k].aok));
      chk($sformatf("vec%0d data_ok", k), 80'({dresp[1].data_ok, dresp[0].data_ok}), 80'(0));
      do_reset();
    end

    // Single cached read, response two cycles after the request cycle
    dreq[0]               = mkreq(0, 32'h8000_0010, 1'b1);
    cache_resp[0].addr_ok = 1'b1;
    #1;
    chk("A cache_req0", 80'(cache_req[0]), 80'(mkreq(0, 32'h0000_0010, 1'b1)));
    chk("A addr_ok", 80'(dresp[0].addr_ok), 80'(1));
    @(negedge clk);
    dreq = '0;
    #1;
    chk("A no data_ok yet", 80'(dresp[0].data_ok), 80'(0));
    @(negedge clk);
    cache_resp[0].data_ok = 1'b1;
    cache_resp[0].data    = 32'hDEAD_BEEF;
    #1;
    chk("A data_ok", 80'(dresp[0].data_ok), 80'(1));
    chk("A data", 80'(dresp[0].data), 80'(32'hDEAD_BEEF));
    @(negedge clk);
    cache_resp[0].data_ok = 1'b0;
    #1;
    chk("A popped", 80'(dresp[0].data), 80'(0));
    do_reset();

    // Mixed issue: port0 uncached, port1 cached on lane 0
    dreq[0]    = mkreq(0, 32'hBFC0_0000, 1'b1);
    dreq[1]    = mkreq(1, 32'h8000_0100, 1'b1);
    cache_resp[0].addr_ok = 1'b1;
    uc_resp[0].addr_ok    = 1'b1;
    #1;
    chk("B uc_req0 addr", 80'(uc_req[0].addr), 80'(32'h1FC0_0000));
    chk("B cache_req0", 80'(cache_req[0]), 80'(mkreq(1, 32'h0000_0100, 1'b1)));
    @(negedge clk);
    dreq = '0;
    uc_resp[0].data_ok    = 1'b1;
    uc_resp[0].data       = 32'hAAAA_0000;
    cache_resp[0].data_ok = 1'b1;
    cache_resp[0].data    = 32'hCCCC_0001;
    #1;
    chk("B p0 resp", 80'(dresp[0]), 80'({1'b1, 1'b1, 32'hAAAA_0000}));
    chk("B p1 resp", 80'(dresp[1]), 80'({1'b1, 1'b1, 32'hCCCC_0001}));
    @(negedge clk);
    uc_resp[0].data_ok    = 1'b0;
    cache_resp[0].data_ok = 1'b0;
    #1;
    chk("B drained", 80'({dresp[1].data, dresp[0].data}), 80'(0));
    do_reset();

    // Backpressure: third request to a full FIFO is refused; a pop frees it a cycle later
    cache_resp[0].addr_ok = 1'b1;
    dreq[0] = mkreq(0, 32'h8000_0020, 1'b1);
    #1;
    chk("C accept1", 80'(dresp[0].addr_ok), 80'(1));
    @(negedge clk);
    #1;
    chk("C accept2", 80'(dresp[0].addr_ok), 80'(1));
    @(negedge clk);
    #1;
    chk("C full addr_ok", 80'(dresp[0].addr_ok), 80'(0));
    chk("C full valid", 80'(cache_req[0].valid), 80'(0));
    @(negedge clk);
    cache_resp[0].data_ok = 1'b1;
    cache_resp[0].data    = 32'h0000_C001;
    #1;
    chk("C pop data_ok", 80'(dresp[0].data_ok), 80'(1));
    chk("C pop same-cycle addr_ok", 80'(dresp[0].addr_ok), 80'(0));
    @(negedge clk);
    cache_resp[0].data_ok = 1'b0;
    #1;
    chk("C slot freed addr_ok", 80'(dresp[0].addr_ok), 80'(1));
    chk("C slot freed valid", 80'(cache_req[0].valid), 80'(1));
    do_reset();

    // Uncached (slow) then cached (fast) on one port: responses return in issue order
    uc_resp[0].addr_ok    = 1'b1;
    cache_resp[0].addr_ok = 1'b1;
    dreq[0] = mkreq(0, 32'hA000_0040, 1'b1);
    #1;
    chk("D uc accept", 80'(dresp[0].addr_ok), 80'(1));
    @(negedge clk);
    dreq[0] = mkreq(0, 32'h8000_0080, 1'b1);
    #1;
    chk("D cached accept", 80'(dresp[0].addr_ok), 80'(1));
    @(negedge clk);
    dreq[0]            = '0;
    uc_resp[0].data    = 32'h1234_5678;
    cache_resp[0].data = 32'h6666_6666;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("D wait%0d", c), 80'(dresp[0].data_ok), 80'(0));
      @(negedge clk);
    end
    uc_resp[0].data_ok = 1'b1;
    uc_resp[0].data    = 32'h5555_5555;
    #1;
    chk("D uncached first", 80'({dresp[0].data_ok, dresp[0].data}), 80'({1'b1, 32'h5555_5555}));
    @(negedge clk);
    uc_resp[0].data_ok    = 1'b0;
    cache_resp[0].data_ok = 1'b1;
    #1;
    chk("D cached second", 80'({dresp[0].data_ok, dresp[0].data}), 80'({1'b1, 32'h6666_6666}));
    @(negedge clk);
    cache_resp[0].data_ok = 1'b0;
    #1;
    chk("D drained", 80'(dresp[0].data), 80'(0));
    do_reset();

    // Reset with two outstanding, then a stale data_ok must be ignored
    cache_resp[0].addr_ok = 1'b1;
    dreq[0] = mkreq(0, 32'h8000_0000, 1'b1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    clear_inputs();
    @(negedge clk);
    reset = 1'b0;
    cache_resp[0].data_ok = 1'b1;
    cache_resp[0].data    = 32'hBAD0_BAD0;
    #1;
    chk("E stale dresp0", 80'(dresp[0]), 80'(0));
    chk("E stale dresp1", 80'(dresp[1]), 80'(0));
    @(negedge clk);
    cache_resp[0].data_ok = 1'b0;
    cache_resp[0].addr_ok = 1'b1;
    dreq[0] = mkreq(0, 32'h8000_0000, 1'b1);
    #1;
    chk("E empty accept1", 80'(dresp[0].addr_ok), 80'(1));
    @(negedge clk);
    #1;
    chk("E empty accept2", 80'(dresp[0].addr_ok), 80'(1));
    @(negedge clk);
    #1;
    chk("E refill full", 80'(dresp[0].addr_ok), 80'(0));
    do_reset();

`ifdef DBUS_ROUTER_PERF_EN
    begin
      logic [31:0] pa [4];
      pa[0] = 32'h8000_0000;
      pa[1] = 32'hA000_0000;
      pa[2] = 32'h8000_0004;
      pa[3] = 32'h8000_0008;
      for (int k = 0; k < 4; k++) begin
        cache_resp[0].addr_ok = 1'b1;
        uc_resp[1].addr_ok    = 1'b1;
        dreq[1] = mkreq(1, pa[k], 1'b1);
        @(negedge clk);
        dreq[1] = '0;
        if (k == 1) uc_resp[1].data_ok = 1'b1;
        else        cache_resp[0].data_ok = 1'b1;
        @(negedge clk);
        uc_resp[1].data_ok    = 1'b0;
        cache_resp[0].data_ok = 1'b0;
      end
      #1;
      chk("P perf port1", 80'(perf_cnt[1]), 80'({32'd3, 32'd1}));
      chk("P perf port0", 80'(perf_cnt[0]), 80'(0));
      do_reset();
      #1;
      chk("P perf cleared", 80'(perf_cnt[1]), 80'(0));
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
